vector_sequencer: RTL and testbench
===================================

VECTOR_SEQUENCER -- requirements
Module: vector_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 10, giving clock cycles from vector apply to output sample; legal range 1..255, otherwise an elaboration error.
REQ-002 SHALL have parameter IDX_W, default 8, giving the vector index width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port start, input, 1, a one-cycle pulse that begins a run.
REQ-006 SHALL have port busy / done / pass, output, 1 each, giving run status.
REQ-007 SHALL have port vec_valid / vec_ready, input / output, 1 each, the vector-load handshake.
REQ-008 SHALL have port vec_ain, vec_bin, vec_cin, input, 8 each, the stimulus.
REQ-009 SHALL have port exp_aout, exp_bout, exp_cout, input, 8 each, the expected response.
REQ-010 SHALL have port vec_last, input, 1, marking the final vector of a run.
REQ-011 SHALL have port ain, bin, cin, output, 8 each, driving the chip under test.
REQ-012 SHALL have port aout, bout, cout, input, 8 each, the chip response.
REQ-013 SHALL have port res_valid / res_ready, output / input, 1 each, the result handshake.
REQ-014 SHALL have port res_mismatch, output, 1, asserted when any compared bit differs.
REQ-015 SHALL have port res_index, output, IDX_W, the vector number; res_got, output, 24, holding {aout,bout,cout} as sampled.
REQ-016 SHALL have port fail_count, output, 8, counting mismatching vectors.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, APPLY, SETTLE, SAMPLE, REPORT, DONE.
REQ-018 SHALL, in IDLE or DONE, move to FETCH on start and clear fail_count and the index; start is ignored in all other states.
REQ-019 SHALL assert vec_ready only in FETCH; on vec_valid&&vec_ready, capture the vector, vec_last and expected values, update ain/bin/cin on that same edge, and enter APPLY.
REQ-020 SHALL hold ain/bin/cin constant from capture until the next capture.
REQ-021 SHALL load the settle timer in APPLY, spend SETTLE_CYCLES-1 cycles in SETTLE, and register aout/bout/cout in SAMPLE, exactly SETTLE_CYCLES+1 edges after capture.
REQ-022 SHALL compute res_mismatch in SAMPLE as a bitwise compare of the sampled and expected values under the mask, and increment fail_count when set, saturating at 255.
REQ-023 SHALL assert res_valid in REPORT with stable res_* until res_ready, which may already be high on entry.
REQ-024 SHALL, on REPORT handshake, go to DONE if vec_last, else to FETCH with the index incremented; the index wraps modulo 2^IDX_W.
REQ-025 SHALL hold busy=1 in FETCH through REPORT; in DONE, hold done=1 and pass=(fail_count==0) until the next start.
REQ-026 SHALL hold the FSM in FETCH indefinitely while vec_valid=0, with no timeout.

Reset
REQ-027 SHALL, on rst, enter IDLE and drive every output to 0: ain, bin, cin, res_*, fail_count, busy, done, pass, vec_ready.
REQ-028 SHALL, on rst mid-run, abandon the run, drop any pending result and clear the index.

Configuration
REQ-029 SHALL, with SEQ_MASK_EN defined, add input exp_mask (24 bits, 1 = compare bit), captured with the vector.
REQ-030 SHALL, without SEQ_MASK_EN, have no exp_mask port and use an all-ones mask.

Structure
REQ-031 SHALL place the state enum, a vec_t struct (stimulus, expected, mask, last) and the SETTLE_CYCLES default in package seq_pkg.
REQ-032 SHALL implement the settle countdown as sub-module settle_timer, with ports load, count and expired.

Verification
REQ-033 SHALL cover a single vector {60,00,00}, with the chip echoing and expected = echo: res_mismatch=0, pass=1, done=1, and sample exactly 11 edges after capture.
REQ-034 SHALL cover four vectors with vector 2 exp_bout wrong by 1 bit: res_index=2 mismatch, fail_count=1, pass=0.
REQ-035 SHALL cover res_ready held low 20 cycles in REPORT: res_* stable, vec_ready=0, and no index advance.
REQ-036 SHALL cover rst asserted during SETTLE of vector 3: all outputs 0 at once; after restart, first res_index=0.
REQ-037 SHALL cover 260 mismatching vectors: fail_count saturates at 255 and res_index wraps 255->0.
REQ-038 SHALL cover, with SEQ_MASK_EN, mask 24'h00FFFF and an aout mismatch: res_mismatch=0.

Source files
------------

// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_pkg
// Brief    : Shared types and constants for the vector sequencer: FSM state
//            encoding, captured-vector record and the masked compare helper.
// Revision : 1.0 - initial release
// ============================================================================
package seq_pkg;

    localparam int SETTLE_CYCLES_DEFAULT = 10;
    localparam int VEC_W                 = 24;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        APPLY  = 3'd2,
        SETTLE = 3'd3,
        SAMPLE = 3'd4,
        REPORT = 3'd5,
        DONE   = 3'd6
    } state_t;

    // One captured vector: stimulus {a,b,c}, expected {a,b,c}, compare mask, last flag
    typedef struct packed {
        logic [VEC_W-1:0] stim;
        logic [VEC_W-1:0] expected;
        logic [VEC_W-1:0] mask;
        logic             last;
    } vec_t;

    // True when any bit selected by the mask differs between response and expectation
    function automatic logic compare_masked(input logic [VEC_W-1:0] got,
                                            input logic [VEC_W-1:0] exp_val,
                                            input logic [VEC_W-1:0] mask);
        return |((got ^ exp_val) & mask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/settle_timer.sv
`default_nettype none
// ============================================================================
// Module   : settle_timer
// Brief    : Down-counter for the settle wait. 'load' presets the counter to
//            'count'; 'expired' flags the final waiting cycle (remaining <= 1)
//            so the FSM can leave on the following edge.
// Revision : 1.0 - initial release
// ============================================================================
module settle_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] count,
    output logic       expired
);

    logic [7:0] r_remaining;

    // Preset on load, otherwise count down and rest at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_remaining <= 8'd0;
        end else if (load) begin
            r_remaining <= count;
        end else if (r_remaining != 8'd0) begin
            r_remaining <= r_remaining - 8'd1;
        end
    end

    assign expired = (r_remaining[7:1] == 7'd0);

endmodule
`default_nettype wire

// File: rtl/vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vector_sequencer
// Brief    : Applies stored test vectors to a chip under test, waits a fixed
//            settle time, samples the response, compares against expectation
//            and reports each result through a valid/ready handshake.
//            Optional feature macro: SEQ_MASK_EN adds a per-vector 24-bit
//            compare mask input (exp_mask); without it every bit is compared.
// Revision : 1.0 - initial release
// ============================================================================
module vector_sequencer
    import seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT,
    parameter int IDX_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [7:0]       vec_ain,
    input  logic [7:0]       vec_bin,
    input  logic [7:0]       vec_cin,
    input  logic [7:0]       exp_aout,
    input  logic [7:0]       exp_bout,
    input  logic [7:0]       exp_cout,
`ifdef SEQ_MASK_EN
    input  logic [23:0]      exp_mask,
`endif
    input  logic             vec_last,
    output logic [7:0]       ain,
    output logic [7:0]       bin,
    output logic [7:0]       cin,
    input  logic [7:0]       aout,
    input  logic [7:0]       bout,
    input  logic [7:0]       cout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_mismatch,
    output logic [IDX_W-1:0] res_index,
    output logic [23:0]      res_got,
    output logic [7:0]       fail_count
);

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
            $error("vector_sequencer: SETTLE_CYCLES must be in 1..255");
        end
    endgenerate

    // SETTLE occupies SETTLE_CYCLES-1 cycles; with a value of 1 it is skipped
    localparam logic [7:0] c_settle_load = 8'(SETTLE_CYCLES - 1);
    localparam logic       c_skip_settle = (SETTLE_CYCLES == 1);

    state_t           r_state;
    state_t           w_next;
    vec_t             r_vec;
    logic [IDX_W-1:0] r_index;
    logic [23:0]      w_mask;
    logic [23:0]      w_got;
    logic             w_mismatch;
    logic             w_capture;
    logic             w_start_ok;
    logic             w_timer_load;
    logic             w_timer_expired;

`ifdef SEQ_MASK_EN
    assign w_mask = exp_mask;
`else
    assign w_mask = 24'hFF_FFFF;
`endif

    assign w_got        = {aout, bout, cout};
    assign w_mismatch   = compare_masked(w_got, r_vec.expected, r_vec.mask);
    assign w_capture    = (r_state == FETCH) && vec_valid;
    assign w_start_ok   = ((r_state == IDLE) || (r_state == DONE)) && start;
    assign w_timer_load = (r_state == APPLY);

    settle_timer u_settle_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (w_timer_load),
        .count   (c_settle_load),
        .expired (w_timer_expired)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: if (start)           w_next = FETCH;
            FETCH:      if (vec_valid)       w_next = APPLY;
            APPLY:      w_next = c_skip_settle ? SAMPLE : SETTLE;
            SETTLE:     if (w_timer_expired) w_next = SAMPLE;
            SAMPLE:     w_next = REPORT;
            REPORT:     if (res_ready)       w_next = r_vec.last ? DONE : FETCH;
            default:    w_next = IDLE;
        endcase
    end

    // Vector capture, response sampling, fail counting and index tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vec        <= '0;
            r_index      <= '0;
            res_index    <= '0;
            res_got      <= 24'd0;
            res_mismatch <= 1'b0;
            fail_count   <= 8'd0;
        end else begin
            if (w_start_ok) begin
                r_index    <= '0;
                fail_count <= 8'd0;
            end
            if (w_capture) begin
                r_vec.stim     <= {vec_ain, vec_bin, vec_cin};
                r_vec.expected <= {exp_aout, exp_bout, exp_cout};
                r_vec.mask     <= w_mask;
                r_vec.last     <= vec_last;
            end
            if (r_state == SAMPLE) begin
                res_got      <= w_got;
                res_mismatch <= w_mismatch;
                res_index    <= r_index;
                if (w_mismatch && (fail_count != 8'hFF)) begin
                    fail_count <= fail_count + 8'd1;
                end
            end
            if ((r_state == REPORT) && res_ready && !r_vec.last) begin
                r_index <= r_index + 1'b1;
            end
        end
    end

    // Chip drive comes straight from the captured stimulus, so it changes only on capture
    assign ain = r_vec.stim[23:16];
    assign bin = r_vec.stim[15:8];
    assign cin = r_vec.stim[7:0];

    assign vec_ready = (r_state == FETCH);
    assign res_valid = (r_state == REPORT);
    assign busy      = (r_state == FETCH)  || (r_state == APPLY)  || (r_state == SETTLE) ||
                       (r_state == SAMPLE) || (r_state == REPORT);
    assign done      = (r_state == DONE);
    assign pass      = (r_state == DONE) && (fail_count == 8'd0);

endmodule
`default_nettype wire

// File: tb/tb_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_sequencer
// Brief    : Self-checking bench for vector_sequencer. Driver pushes expected
//            results into a scoreboard queue; a monitor pops and compares on
//            every accepted result.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vector_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, pass;
    logic        vec_valid = 1'b0;
    logic        vec_ready;
    logic [7:0]  vec_ain = 8'd0, vec_bin = 8'd0, vec_cin = 8'd0;
    logic [7:0]  exp_aout = 8'd0, exp_bout = 8'd0, exp_cout = 8'd0;
    logic [23:0] exp_mask = 24'hFF_FFFF;
    logic        vec_last = 1'b0;
    logic [7:0]  ain, bin, cin;
    logic [7:0]  aout, bout, cout;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic        res_mismatch;
    logic [7:0]  res_index;
    logic [23:0] res_got;
    logic [7:0]  fail_count;

    // Chip model: echoes its inputs, optionally corrupted by chip_xor
    logic [23:0] chip_xor = 24'd0;
    assign aout = ain ^ chip_xor[23:16];
    assign bout = bin ^ chip_xor[15:8];
    assign cout = cin ^ chip_xor[7:0];

    vector_sequencer #(.SETTLE_CYCLES(10), .IDX_W(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .busy(busy), .done(done), .pass(pass),
        .vec_valid(vec_valid), .vec_ready(vec_ready),
        .vec_ain(vec_ain), .vec_bin(vec_bin), .vec_cin(vec_cin),
        .exp_aout(exp_aout), .exp_bout(exp_bout), .exp_cout(exp_cout),
`ifdef SEQ_MASK_EN
        .exp_mask(exp_mask),
`endif
        .vec_last(vec_last),
        .ain(ain), .bin(bin), .cin(cin),
        .aout(aout), .bout(bout), .cout(cout),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_mismatch(res_mismatch), .res_index(res_index),
        .res_got(res_got), .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [23:0] got;
        logic        mm;
        int          fc;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   exp_idx = 0;
    int   exp_fc  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: compare every accepted result against the oldest expectation
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 64'(res_index), 64'hFFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("res_index",    64'(res_index),    64'(e.idx));
                check("res_got",      64'(res_got),      64'(e.got));
                check("res_mismatch", 64'(res_mismatch), 64'(e.mm));
                check("fail_count",   64'(fail_count),   64'(e.fc));
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        exp_idx = 0;
        exp_fc  = 0;
    endtask

    // Offer one vector, push its expected result, return 1 time unit after capture
    task automatic send_vec(input logic [23:0] stim, input logic [23:0] expv,
                            input logic [23:0] mask, input logic last, input logic exp_mm);
        int   n;
        exp_t e;
        n = 0;
        {vec_ain, vec_bin, vec_cin}    = stim;
        {exp_aout, exp_bout, exp_cout} = expv;
        exp_mask  = mask;
        vec_last  = last;
        vec_valid = 1'b1;
        while (!vec_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            check("vec_ready_timeout", 64'(n), 64'd0);
            vec_valid = 1'b0;
            return;
        end
        if (exp_mm && exp_fc != 255) exp_fc++;
        e.idx = exp_idx;
        e.got = stim ^ chip_xor;
        e.mm  = exp_mm;
        e.fc  = exp_fc;
        sb.push_back(e);
        if (!last) exp_idx = (exp_idx + 1) % 256;
        @(posedge clk);
        #1 vec_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done_timeout"}, 64'(n >= 2000), 64'd0);
    endtask

    task automatic check_zero(input string name);
        check({name, "_chip_drive"}, 64'({ain, bin, cin}), 64'd0);
        check({name, "_res"}, 64'({res_valid, res_mismatch, res_index, res_got}), 64'd0);
        check({name, "_fail_count"}, 64'(fail_count), 64'd0);
        check({name, "_status"}, 64'({busy, done, pass, vec_ready}), 64'd0);
    endtask

    initial begin
        int          n;
        logic [23:0] snap_got;
        logic [7:0]  snap_idx;
        logic        snap_mm;

        // Reset state
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Single vector {60,00,00}, echoing chip, latency from capture to result
        pulse_start();
        send_vec(24'h600000, 24'h600000, 24'hFF_FFFF, 1'b1, 1'b0);
        check("t1_ain_on_capture", 64'(ain), 64'h60);
        n = 0;
        while (!res_valid && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        check("t1_capture_to_result_edges", 64'(n), 64'd11);
        wait_done("t1");
        check("t1_pass", 64'({done, pass, busy}), 64'b110);

        // Four vectors, vector 2 exp_bout wrong by one bit
        pulse_start();
        send_vec(24'h112233, 24'h112233, 24'hFF_FFFF, 1'b0, 1'b0);
        send_vec(24'h445566, 24'h445566, 24'hFF_FFFF, 1'b0, 1'b0);
        send_vec(24'h778899, 24'h778999, 24'hFF_FFFF, 1'b0, 1'b1);
        send_vec(24'hAABBCC, 24'hAABBCC, 24'hFF_FFFF, 1'b1, 1'b0);
        wait_done("t2");
        check("t2_fail_count", 64'(fail_count), 64'd1);
        check("t2_pass", 64'({done, pass}), 64'b10);

        // Result held 20 cycles with res_ready low
        pulse_start();
        res_ready = 1'b0;
        send_vec(24'h0F0F0F, 24'h0F0F0F, 24'hFF_FFFF, 1'b0, 1'b0);
        n = 0;
        while (!res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t3_result_timeout", 64'(n >= 50), 64'd0);
        snap_got = res_got;
        snap_idx = res_index;
        snap_mm  = res_mismatch;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t3_hold", 64'({res_valid, vec_ready, res_got, res_index, res_mismatch}),
                  64'({1'b1, 1'b0, snap_got, snap_idx, snap_mm}));
        end
        @(posedge clk);
        #1 res_ready = 1'b1;
        send_vec(24'hF0F0F0, 24'hF0F0F0, 24'hFF_FFFF, 1'b1, 1'b0);
        wait_done("t3");

        // Reset during SETTLE of vector 3, then restart
        pulse_start();
        send_vec(24'h010203, 24'h010203, 24'hFF_FFFF, 1'b0, 1'b0);
        send_vec(24'h040506, 24'h040506, 24'hFF_FFFF, 1'b0, 1'b0);
        send_vec(24'h070809, 24'h070809, 24'hFF_FFFF, 1'b0, 1'b0);
        send_vec(24'h0A0B0C, 24'h0A0B0C, 24'hFF_FFFF, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("t4_busy_before_rst", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1 check_zero("t4_async_rst");
        sb.delete();
        @(negedge clk) rst = 1'b0;
        pulse_start();
        send_vec(24'h123456, 24'h123456, 24'hFF_FFFF, 1'b1, 1'b0);
        wait_done("t4");

        // 260 mismatching vectors: fail_count saturation, index wrap
        chip_xor = 24'h000001;
        pulse_start();
        for (int i = 0; i < 260; i++) begin
            send_vec({i[7:0], 8'h5A, 8'hC3}, {i[7:0], 8'h5A, 8'hC3}, 24'hFF_FFFF,
                     (i == 259), 1'b1);
        end
        wait_done("t5");
        check("t5_fail_sat", 64'(fail_count), 64'd255);
        check("t5_pass", 64'({done, pass}), 64'b10);
        chip_xor = 24'd0;

`ifdef SEQ_MASK_EN
        // aout corrupted but masked out
        chip_xor = 24'h010000;
        pulse_start();
        send_vec(24'hA5A5A5, 24'hA5A5A5, 24'h00FFFF, 1'b1, 1'b0);
        wait_done("t6");
        check("t6_pass", 64'({done, pass}), 64'b11);
        chip_xor = 24'd0;
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
